// File: rtl/rf_pkg.sv
// Shared register-file constants, requester IDs and the writeback tie-break helper.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_LSU = 1'b1;

    // A lone requester always wins; prio only matters when both are valid.
    function automatic logic wb_winner(input logic alu_valid,
                                       input logic lsu_valid,
                                       input logic prio);
        if (alu_valid && lsu_valid) begin
            return prio;
        end else if (lsu_valid) begin
            return WB_LSU;
        end else begin
            return WB_ALU;
        end
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write mask; a same-cycle set beats a clear, and x0 is never pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    output logic [2**ADDR_W-1:0]   pending
);

    logic [2**ADDR_W-1:0] set_mask;
    logic [2**ADDR_W-1:0] clr_mask;
    logic [2**ADDR_W-1:0] pend_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_addr != '0)) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end
        pend_next    = (pending & ~clr_mask) | set_mask;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pend_next;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ALU/LSU writeback arbiter driving the register file write port, plus pending scoreboard.
// Define RF_WB_FIXED_PRIO_EN to make the LSU win every tie instead of round-robin.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   lsu_valid,
    input  logic [ADDR_W-1:0]      lsu_addr,
    input  logic [DATA_W-1:0]      lsu_data,
    output logic                   lsu_ready,
    input  logic                   pend_set,
    input  logic [ADDR_W-1:0]      pend_addr,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [2**ADDR_W-1:0]   pending
);

    logic              prio;
    logic              winner;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

`ifdef RF_WB_FIXED_PRIO_EN
    assign prio = WB_LSU;
`else
    // After a contested grant the loser gets the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= WB_ALU;
        end else if (alu_valid && lsu_valid) begin
            prio <= ~prio;
        end
    end
`endif

    always_comb begin
        winner    = wb_winner(alu_valid, lsu_valid, prio);
        accept    = !reset && (alu_valid || lsu_valid);
        alu_ready = accept && (winner == WB_ALU);
        lsu_ready = accept && (winner == WB_LSU);
        win_addr  = (winner == WB_LSU) ? lsu_addr : alu_addr;
        win_data  = (winner == WB_LSU) ? lsu_data : alu_data;
    end

    // x0 writes are accepted and registered but never enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (accept) begin
            rf_we    <= (win_addr != '0);
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (pend_set),
        .set_addr (pend_addr),
        .clr_en   (rf_we),
        .clr_addr (rf_waddr),
        .pending  (pending)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter against a cycle-level reference model.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid, pend_set;
    logic [4:0]  alu_addr, lsu_addr, pend_addr;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: write-port contents, one flag per register, and whose turn a tie is.
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    bit        m_pend [32];
    int        m_turn;

    // Upstream requesters: each holds its request until the model says it was taken.
    bit        ra_v, rl_v;
    bit [4:0]  ra_a, rl_a;
    bit [31:0] ra_d, rl_d;
    bit        last_ar, last_lr;
    int        alu_grants;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ps, input bit [4:0] pa);
        bit        ear, elr;
        bit [31:0] pm;
        reset     = rst;
        alu_valid = ra_v; alu_addr = ra_a; alu_data = ra_d;
        lsu_valid = rl_v; lsu_addr = rl_a; lsu_data = rl_d;
        pend_set  = ps;   pend_addr = pa;
        #3;
        if (rst) begin
            ear = 0; elr = 0;
        end else if (ra_v && rl_v) begin
`ifdef RF_WB_FIXED_PRIO_EN
            ear = 0;
`else
            ear = (m_turn == 0);
`endif
            elr = !ear;
        end else begin
            ear = ra_v; elr = rl_v;
        end
        checkOutput("alu_ready", alu_ready, ear);
        checkOutput("lsu_ready", lsu_ready, elr);
        last_ar = alu_ready;
        last_lr = lsu_ready;
        @(posedge clk);
        if (rst) begin
            m_we = 0; m_waddr = 0; m_wdata = 0; m_turn = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else begin
            if (m_we) m_pend[m_waddr] = 0;
            if (ps && pa != 0) m_pend[pa] = 1;
            if (ra_v && rl_v) m_turn = 1 - m_turn;
            if (ear) begin
                m_we = (ra_a != 0); m_waddr = ra_a; m_wdata = ra_d;
            end else if (elr) begin
                m_we = (rl_a != 0); m_waddr = rl_a; m_wdata = rl_d;
            end else begin
                m_we = 0;
            end
        end
        #1;
        pm = '0;
        foreach (m_pend[i]) pm[i] = m_pend[i];
        checkOutput("rf_we", rf_we, m_we);
        checkOutput("rf_waddr", rf_waddr, m_waddr);
        checkOutput("rf_wdata", rf_wdata, m_wdata);
        checkOutput("pending", pending, pm);
        if (ear) ra_v = 0;
        if (elr) rl_v = 0;
    endtask

    initial begin
        reset = 1; alu_valid = 0; lsu_valid = 0; pend_set = 0;
        alu_addr = 0; lsu_addr = 0; pend_addr = 0; alu_data = 0; lsu_data = 0;
        ra_v = 0; rl_v = 0; ra_a = 0; rl_a = 0; ra_d = 0; rl_d = 0;
        @(posedge clk); #1;

        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("idle_we", rf_we, 0);
        checkOutput("idle_pending", pending, 0);

        // First tie after reset.
        ra_v = 1; ra_a = 5; ra_d = 32'h11;
        rl_v = 1; rl_a = 6; rl_d = 32'h22;
        applyStimulus(0, 0, 0);
`ifndef RF_WB_FIXED_PRIO_EN
        checkOutput("tie1_waddr", rf_waddr, 5);
        checkOutput("tie1_wdata", rf_wdata, 32'h11);
`endif
        applyStimulus(0, 0, 0);
`ifndef RF_WB_FIXED_PRIO_EN
        checkOutput("tie2_waddr", rf_waddr, 6);
`endif

        // Sustained contention: refill whichever side was just accepted.
        ra_v = 1; ra_a = 10; ra_d = 32'hA0;
        rl_v = 1; rl_a = 20; rl_d = 32'hB0;
        alu_grants = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0);
            if (last_ar) alu_grants++;
            if (!ra_v) begin ra_v = 1; ra_a = ra_a + 1; ra_d = ra_d + 1; end
            if (!rl_v) begin rl_v = 1; rl_a = rl_a + 1; rl_d = rl_d + 1; end
        end
`ifdef RF_WB_FIXED_PRIO_EN
        checkOutput("alu_grants", alu_grants, 0);
`else
        checkOutput("alu_grants", alu_grants, 2);
`endif
        for (int k = 0; k < 8 && (ra_v || rl_v); k++) applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);

        // Write to x0 is accepted but never enabled.
        ra_v = 1; ra_a = 0; ra_d = 32'hDEAD;
        applyStimulus(0, 0, 0);
        checkOutput("x0_ready", last_ar, 1);
        checkOutput("x0_we", rf_we, 0);

        // pend_set x7, then LSU write to x7 clears it two cycles after accept.
        applyStimulus(0, 1, 7);
        rl_v = 1; rl_a = 7; rl_d = 32'h77;
        applyStimulus(0, 0, 0);
        checkOutput("p7_after_accept", pending[7], 1);
        applyStimulus(0, 0, 0);
        checkOutput("p7_cleared", pending[7], 0);
        applyStimulus(0, 1, 7);
        rl_v = 1; rl_a = 7; rl_d = 32'h78;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 7);
        checkOutput("p7_set_wins", pending[7], 1);
        applyStimulus(0, 0, 0);

        // Reset the cycle after an accept drops the write and clears the scoreboard.
        ra_v = 1; ra_a = 9; ra_d = 32'h99;
        applyStimulus(0, 1, 9);
        applyStimulus(1, 0, 0);
        checkOutput("rst_we", rf_we, 0);
        checkOutput("rst_pending", pending, 0);
        applyStimulus(0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            bit        rst, ps;
            bit [4:0]  pa;
            if (!ra_v && $urandom_range(0, 9) < 6) begin
                ra_v = 1; ra_a = 5'($urandom_range(0, 15)); ra_d = $urandom;
            end
            if (!rl_v && $urandom_range(0, 9) < 6) begin
                rl_v = 1; rl_a = 5'($urandom_range(0, 15)); rl_d = $urandom;
            end
            rst = ($urandom_range(0, 99) < 2);
            ps  = ($urandom_range(0, 2) == 0);
            pa  = 5'($urandom_range(0, 15));
            applyStimulus(rst, ps, pa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
